// File: rtl/bpm_acq_ctrl_if.sv
// DigitalBlock-facing bundle: soft reset, sample strobe and the result handshake.
// master = acquisition controller, slave = DigitalBlock.
interface bpm_acq_ctrl_if;
  logic       dblk_rst_n;
  logic       dblk_en;
  logic [7:0] bpm_value;
  logic       bpm_valid;
  logic       bpm_copied;

  modport master (
    output dblk_rst_n,
    output dblk_en,
    output bpm_copied,
    input  bpm_value,
    input  bpm_valid
  );

  modport slave (
    input  dblk_rst_n,
    input  dblk_en,
    input  bpm_copied,
    output bpm_value,
    output bpm_valid
  );
endinterface

// File: rtl/bpm_acq_ctrl.sv
// Acquisition sequencer for the DigitalBlock BPM datapath with a small result FIFO.
// Optional BPM_AVG_EN: push a 4-tap moving average of accepted values instead of raw ones.
module bpm_acq_ctrl #(
  parameter int unsigned CLK_DIV         = 100,
  parameter int unsigned WARMUP_BEATS    = 2,
  parameter int unsigned TIMEOUT_SAMPLES = 255,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned BPM_MIN         = 30,
  parameter int unsigned BPM_MAX         = 220
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           stop,
  bpm_acq_ctrl_if.master dblk,
  input  logic           rd_en,
  output logic [7:0]     rd_data,
  output logic           fifo_empty,
  output logic           fifo_full,
  output logic           overflow,
  output logic           no_pulse,
  output logic [1:0]     state
);

  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TickW = (TIMEOUT_SAMPLES > 0) ? $clog2(TIMEOUT_SAMPLES + 1) : 1;
  localparam int unsigned WarmW = (WARMUP_BEATS > 0) ? $clog2(WARMUP_BEATS + 1) : 1;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [TickW-1:0] TickMax  = TickW'(TIMEOUT_SAMPLES);
  localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP_BEATS);
  localparam logic [CntW-1:0]  Depth    = CntW'(FIFO_DEPTH);
  localparam logic [7:0]       BpmLo    = 8'(BPM_MIN);
  localparam logic [7:0]       BpmHi    = 8'(BPM_MAX);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWarmup  = 2'd1,
    StRun     = 2'd2,
    StNoPulse = 2'd3
  } state_e;

  state_e          state_q;
  logic [DivW-1:0] div_q, div_next;
  logic [TickW-1:0] tick_q;
  logic [WarmW-1:0] warm_q, warm_inc;
  logic            ack_pending_q;
  logic            bpm_copied_q;
  logic            dblk_rst_n_q;
  logic            dblk_en_q;
  logic            overflow_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic            start_go, capture, in_range, accept;
  logic            empty, full, pop, push, drop;
  logic [7:0]      push_data;

  always_comb begin
    start_go = start && !stop && (state_q == StIdle);
    capture  = (state_q != StIdle) && dblk.bpm_valid && !ack_pending_q;
    in_range = (dblk.bpm_value >= BpmLo) && (dblk.bpm_value <= BpmHi);
    accept   = capture && in_range && ((state_q == StRun) || (state_q == StNoPulse));
    empty    = (count_q == '0);
    full     = (count_q == Depth);
    // A clearing start takes precedence over a host pop in the same cycle.
    pop      = rd_en && !empty && !start_go;
    push     = accept && (!full || pop);
    drop     = accept && full && !pop;
    div_next = (div_q == DivLast) ? '0 : div_q + 1'b1;
    warm_inc = warm_q + 1'b1;
  end

  // Sequencer: state, divider, tick/warm-up counters and all DigitalBlock-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      div_q         <= '0;
      tick_q        <= '0;
      warm_q        <= '0;
      ack_pending_q <= 1'b0;
      bpm_copied_q  <= 1'b0;
      dblk_rst_n_q  <= 1'b0;
      dblk_en_q     <= 1'b0;
    end else begin
      bpm_copied_q  <= capture;
      ack_pending_q <= capture || (ack_pending_q && dblk.bpm_valid);
      if (stop) begin
        state_q      <= StIdle;
        dblk_rst_n_q <= 1'b0;
        dblk_en_q    <= 1'b0;
      end else if (state_q == StIdle) begin
        if (start) begin
          state_q      <= (WARMUP_BEATS == 0) ? StRun : StWarmup;
          div_q        <= '0;
          tick_q       <= '0;
          warm_q       <= '0;
          dblk_rst_n_q <= 1'b1;
          dblk_en_q    <= 1'b0;
        end
      end else begin
        div_q     <= div_next;
        dblk_en_q <= (div_next == DivLast);
        if (capture) begin
          tick_q <= '0;
        end else if (dblk_en_q && (tick_q != TickMax)) begin
          tick_q <= tick_q + 1'b1;
        end
        case (state_q)
          StWarmup: begin
            if (capture) begin
              warm_q <= warm_inc;
              if (warm_inc == WarmLast) state_q <= StRun;
            end else if (tick_q == TickMax) begin
              state_q <= StNoPulse;
            end
          end
          StRun: begin
            if (!capture && (tick_q == TickMax)) state_q <= StNoPulse;
          end
          StNoPulse: begin
            if (accept) state_q <= StRun;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (start_go) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

`ifdef BPM_AVG_EN
  // The incoming value is the fourth tap; only the three previous accepted values are stored.
  logic [7:0] hist_q [3];
  logic       hist_live_q;
  logic       preload;
  logic [9:0] avg_sum;

  always_comb begin
    preload = !hist_live_q || (state_q != StRun);
    if (preload) begin
      avg_sum = {dblk.bpm_value, 2'b00} + 10'd2;
    end else begin
      avg_sum = 10'(dblk.bpm_value) + 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2]) + 10'd2;
    end
    push_data = avg_sum[9:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_live_q <= 1'b0;
      hist_q[0]   <= '0;
      hist_q[1]   <= '0;
      hist_q[2]   <= '0;
    end else if (start_go) begin
      hist_live_q <= 1'b0;
    end else if (accept) begin
      hist_live_q <= 1'b1;
      hist_q[0]   <= dblk.bpm_value;
      hist_q[1]   <= preload ? dblk.bpm_value : hist_q[0];
      hist_q[2]   <= preload ? dblk.bpm_value : hist_q[1];
    end
  end
`else
  assign push_data = dblk.bpm_value;
`endif

  assign dblk.dblk_rst_n = dblk_rst_n_q;
  assign dblk.dblk_en    = dblk_en_q;
  assign dblk.bpm_copied = bpm_copied_q;
  assign rd_data         = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign fifo_empty      = empty;
  assign fifo_full       = full;
  assign overflow        = overflow_q;
  assign no_pulse        = (state_q == StNoPulse);
  assign state           = state_q;

endmodule
